// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The state encoding is used by seq_restoring_divider.
// N and the counter width are given for the default operand format.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_FRAC  = 8;
  localparam int DIV_N     = DIV_WIDTH + DIV_FRAC;
  localparam int DIV_CNT_W = $clog2(DIV_N + 1);

  // Saturated quotient, used for divide-by-zero and overflow results.
  localparam logic [DIV_WIDTH-1:0] DIV_SAT = '1;

  // Step counter width for a given number of shift-subtract steps.
  function automatic int div_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_row.sv
// One restoring shift-subtract row: trial-subtract the divisor from the
// shifted partial remainder and keep the difference only when it is non-negative.
module div_row #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   r_shift,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // Trial subtraction and restore decision.
  always_comb begin
    diff   = r_shift - {1'b0, b};
    q_bit  = (r_shift >= {1'b0, b});
    r_next = q_bit ? diff : r_shift;
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned fixed-point divider, q = (a << FRAC) / b, one restoring step per clock.
// Optional macro DIV_ROUND_EN: one extra guard step and round-half-up of the
// quotient, with saturation checked after rounding.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int N = WIDTH + FRAC;
`ifdef DIV_ROUND_EN
  localparam int STEPS = N + 1;
`else
  localparam int STEPS = N;
`endif
  localparam int CW = div_cnt_w(N);

  state_t             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [N-1:0]       d_reg;
  logic [WIDTH:0]     r_reg;
  logic [STEPS-1:0]   q_acc_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               dz_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               div_by_zero_reg;
  logic               overflow_reg;

  logic [WIDTH:0]     r_shift;
  logic [WIDTH:0]     r_next;
  logic               q_bit;
  logic [WIDTH-1:0]   res_q;
  logic               res_ovf;

  assign r_shift = {r_reg[WIDTH-1:0], d_reg[N-1]};

  div_row #(.WIDTH(WIDTH)) u_row (
    .r_shift (r_shift),
    .b       (b_reg),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

`ifdef DIV_ROUND_EN
  logic [STEPS-1:0] rounded;
  // Drop the guard bit, add it back as the rounding increment, then range-check.
  always_comb begin
    rounded = {1'b0, q_acc_reg[STEPS-1:1]} + STEPS'(q_acc_reg[0]);
    res_ovf = |rounded[STEPS-1:WIDTH];
    res_q   = res_ovf ? '1 : rounded[WIDTH-1:0];
  end
`else
  // Any quotient bit above WIDTH means the result does not fit and saturates.
  always_comb begin
    res_ovf = |q_acc_reg[N-1:WIDTH];
    res_q   = res_ovf ? '1 : q_acc_reg[WIDTH-1:0];
  end
`endif

  // Control FSM, shift-subtract datapath and registered result/handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      d_reg           <= '0;
      r_reg           <= '0;
      q_acc_reg       <= '0;
      b_reg           <= '0;
      dz_reg          <= 1'b0;
      in_ready_reg    <= 1'b1;
      out_valid_reg   <= 1'b0;
      q_reg           <= '0;
      div_by_zero_reg <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            in_ready_reg <= 1'b0;
            b_reg        <= b;
            if (b == '0) begin
              dz_reg    <= 1'b1;
              state_reg <= DONE;
            end else begin
              dz_reg    <= 1'b0;
              d_reg     <= {a, {FRAC{1'b0}}};
              r_reg     <= '0;
              q_acc_reg <= '0;
              cnt_reg   <= CW'(STEPS - 1);
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          d_reg     <= {d_reg[N-2:0], 1'b0};
          r_reg     <= r_next;
          q_acc_reg <= {q_acc_reg[STEPS-2:0], q_bit};
          if (cnt_reg == '0) begin
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle registers the result; afterwards it holds until taken.
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
            if (dz_reg) begin
              q_reg           <= '1;
              div_by_zero_reg <= 1'b1;
              overflow_reg    <= 1'b0;
            end else begin
              q_reg           <= res_q;
              div_by_zero_reg <= 1'b0;
              overflow_reg    <= res_ovf;
            end
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign q           = q_reg;
  assign div_by_zero = div_by_zero_reg;
  assign overflow    = overflow_reg;

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Unsigned fixed-point divider computing q = (a << FRAC) / b with one restoring shift-subtract step per clock.
- It is the inverse of the partial-product array in the multiplier path. Each row there is gated by a known multiplier bit; here each row decides one quotient bit from a trial subtraction.
- Serves as the area-cheap reference divider alongside the Goldschmidt datapath. It also produces golden quotients for that datapath.

Parameters:
- WIDTH, 16, operand and quotient width in bits.
- FRAC, 8, fractional bits of the Qm.FRAC format shared by a, b and q.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  divider idle and able to accept.
- a  input  WIDTH  dividend, unsigned Q(WIDTH-FRAC).FRAC.
- b  input  WIDTH  divisor, same format.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts result.
- q  output  WIDTH  quotient, same format.
- div_by_zero  output  1  b was 0 for this result.
- overflow  output  1  true quotient exceeded the WIDTH range and was saturated.

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE; in_ready=1, out_valid=0, q=0, div_by_zero=0, overflow=0; counter and remainder cleared.
  - Reset mid-operation abandons the division with no output.
- Let N = WIDTH+FRAC.
- States:
  - IDLE: in_ready=1. The handshake in_valid&in_ready latches a and b.
    - If b==0, go to DONE next cycle with q={WIDTH{1}}, div_by_zero=1, overflow=0.
    - Otherwise load the working dividend D = a<<FRAC (N bits), remainder R=0 (WIDTH+1 bits), counter=N-1, and go to RUN.
  - RUN: in_ready=0. Each cycle does one step:
    - R' = {R[WIDTH-1:0], D msb}; D shifts left by 1.
    - If R' >= b, then R = R'-b and the quotient bit is 1; else R = R' and the quotient bit is 0.
    - The quotient bit shifts into the N-bit Q register.
    - After the step with counter==0, go to DONE; otherwise decrement the counter.
  - DONE: out_valid=1, and outputs stay stable until out_ready.
    - If Q[N-1:WIDTH] != 0, drive q={WIDTH{1}} and overflow=1; else q=Q[WIDTH-1:0] and overflow=0.
    - On out_valid&out_ready, go to IDLE. in_ready returns to 1 the following cycle; there is no same-cycle accept while in DONE.
- Latency:
  - Accept edge is cycle 0; out_valid is first high in cycle N+1 (25 for the defaults).
  - Divide-by-zero results appear in cycle 1.
- Result is truncated toward zero. No signed support.
- The in_valid/a/b inputs are ignored outside IDLE.

Optional Feature:
- Macro: DIV_ROUND_EN.
- Defined:
  - RUN performs N+1 steps; the extra quotient bit is a guard bit.
  - In DONE, q = (Q>>1) + guard, i.e. round half up.
  - Overflow is tested after rounding, so a carry out of WIDTH bits saturates and sets overflow.
  - Latency becomes N+2.
- Undefined: truncating behaviour and latency as above.

Decomposition:
- Package div_pkg:
  - state enum IDLE/RUN/DONE (2-bit encoding);
  - localparam N and counter width $clog2(N+1);
  - the saturation constant.
- Sub-module div_row: combinational single restoring step.
  - Inputs: R', b.
  - Outputs: next R and the quotient bit.
  - Keeps the subtract row isolated, so it can later be unrolled into an array matching the multiplier's row structure.

Test Plan:
- a=0x0300, b=0x0200 (3.0/2.0) -> q=0x0180, flags 0, out_valid first high 25 cycles after accept (26 with DIV_ROUND_EN).
- a=0x0200, b=0x0300 (2/3) -> q=0x00AA truncated; q=0x00AB with DIV_ROUND_EN.
- a=0x1234, b=0x0000 -> q=0xFFFF, div_by_zero=1, overflow=0, out_valid in cycle 1.
- a=0xFF00, b=0x0080 (255/0.5) -> q=0xFFFF, overflow=1, div_by_zero=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Required: q and flags stable, in_ready=0, and a new in_valid is ignored.
  - Then out_ready=1 for one cycle: in_ready=1 the next cycle, and the next operation (0x0100/0x0100) -> 0x0100.
- Assert rst during cycle 10 of RUN.
  - Required: outputs return to reset values immediately, in_ready=1 after release, and no spurious out_valid.
  - A subsequent 0x0300/0x0200 still yields 0x0180.
